// File: rtl/wb_grf.sv
// Write-back stage and general register file.
// Selects/extends the W-stage result, commits it, and serves two read ports.
module wb_grf #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_W,
  input  logic [31:0] PC_W,
  input  logic [4:0]  RFWA_W,
  input  logic [31:0] ALUout_W,
  input  logic [31:0] HI_W,
  input  logic [31:0] LO_W,
  input  logic [31:0] DMRD_W,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        WE_W,
  output logic [31:0] WD_W
);

  logic [31:0] grf_q [1:31];

  logic [5:0]  op;
  logic [5:0]  fn;
  logic        rtype;
  logic        is_lw, is_lh, is_lhu;
  logic        is_lb, is_lbu, is_link;
  logic        is_hi, is_lo;
  logic [7:0]  byte_w;
  logic [15:0] half_w;
  logic        unused_ok;

  // RESET_PC lives in the MW register; rs/rt/rd/shamt play no role here
  assign unused_ok = ^{RESET_PC, Instr_W[25:6]};

  assign op    = Instr_W[31:26];
  assign fn    = Instr_W[5:0];
  assign rtype = (op == 6'b000000);

  assign is_lw   = (op == 6'b100011);
  assign is_lh   = (op == 6'b100001);
  assign is_lhu  = (op == 6'b100101);
  assign is_lb   = (op == 6'b100000);
  assign is_lbu  = (op == 6'b100100);
  assign is_link = (op == 6'b000011)
                 | (rtype & (fn == 6'b001001));
  assign is_hi   = rtype & (fn == 6'b010000);
  assign is_lo   = rtype & (fn == 6'b010010);

  always_comb begin
    byte_w = DMRD_W[7:0];
    unique case (ALUout_W[1:0])
      2'd0: byte_w = DMRD_W[7:0];
      2'd1: byte_w = DMRD_W[15:8];
      2'd2: byte_w = DMRD_W[23:16];
      2'd3: byte_w = DMRD_W[31:24];
      default: byte_w = DMRD_W[7:0];
    endcase
    half_w = ALUout_W[1] ? DMRD_W[31:16]
                         : DMRD_W[15:0];
  end

  always_comb begin
    WD_W = ALUout_W;
    unique case (1'b1)
      is_lw:   WD_W = DMRD_W;
      is_lh:   WD_W = {{16{half_w[15]}}, half_w};
      is_lhu:  WD_W = {16'h0, half_w};
      is_lb:   WD_W = {{24{byte_w[7]}}, byte_w};
      is_lbu:  WD_W = {24'h0, byte_w};
      is_link: WD_W = PC_W + 32'd8;
      is_hi:   WD_W = HI_W;
      is_lo:   WD_W = LO_W;
      default: WD_W = ALUout_W;
    endcase
  end

  assign WE_W = (RFWA_W != 5'd0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++)
        grf_q[i] <= 32'h0;
    end else if (WE_W) begin
      grf_q[RFWA_W] <= WD_W;
    end
  end

  // Bypass gives write-before-read behaviour to the D stage
  always_comb begin
    if (A1 == 5'd0)
      RD1 = 32'h0;
    else if (WE_W && (A1 == RFWA_W))
      RD1 = WD_W;
    else
      RD1 = grf_q[A1];
  end

  always_comb begin
    if (A2 == 5'd0)
      RD2 = 32'h0;
    else if (WE_W && (A2 == RFWA_W))
      RD2 = WD_W;
    else
      RD2 = grf_q[A2];
  end

endmodule
